// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame packer.
// Holds the frame FSM state encoding, sync bytes and the CRC-8 step used when FRAME_CRC_EN is defined.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_SEQ,
        ST_PAYLOAD,
        ST_CHK,
        ST_DONE
    } frame_state_t;

    localparam logic [7:0] SYNC0     = 8'hA5;
    localparam logic [7:0] SYNC1     = 8'h5A;
    localparam logic [7:0] CRC8_POLY = 8'h07;

    // CRC-8, MSB first, no reflection: fold the whole byte in, then shift out 8 bits.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ CRC8_POLY) : {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/uart_byte_pacer.sv
// Byte pacer for uart_tx: one issue per UART character, never two write strobes back to back.
// holdoff is set on issue and released on the first cycle uart_rdy is seen low.
module uart_byte_pacer (
    input  logic clk,
    input  logic rst,
    input  logic uart_rdy,
    input  logic issue_req,
    output logic issue_ok,
    output logic issue,
    output logic wreq
);

    logic holdoff;

    assign issue_ok = uart_rdy & ~holdoff;
    assign issue    = issue_ok & issue_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            holdoff <= 1'b0;
            wreq    <= 1'b0;
        end else begin
            wreq <= issue;
            if (issue) begin
                holdoff <= 1'b1;
            end else if (!uart_rdy) begin
                holdoff <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/uart_frame_packer.sv
// uart_frame_packer: wraps a valid/ready byte stream into A5 5A SEQ payload CHK frames paced by uart_rdy.
// Define FRAME_CRC_EN to make CHK a CRC-8 (poly 0x07) instead of the mod-256 payload sum.
module uart_frame_packer
    import uart_frame_pkg::*;
#(
    parameter int unsigned       N_data    = 8,
    parameter int unsigned       FRAME_LEN = 64,
    parameter logic [N_data-1:0] PAD_BYTE  = '0
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              start,
    input  logic              s_valid,
    input  logic [N_data-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    input  logic              uart_rdy,
    output logic              uart_wreq,
    output logic [N_data-1:0] uart_wdata,
    output logic [7:0]        frame_seq,
    output logic              busy,
    output logic              done
);

    localparam logic [7:0] LAST_SLOT = 8'(FRAME_LEN - 1);

    frame_state_t      state, state_nx;
    logic              issue_req, issue_ok, issue;
    logic [N_data-1:0] tx_byte;
    logic [7:0]        chk, chk_next;
    logic [7:0]        pay_cnt;
    logic              last_seen;

    uart_byte_pacer u_pacer (
        .clk       (clk_50M),
        .rst       (rst),
        .uart_rdy  (uart_rdy),
        .issue_req (issue_req),
        .issue_ok  (issue_ok),
        .issue     (issue),
        .wreq      (uart_wreq)
    );

`ifdef FRAME_CRC_EN
    assign chk_next = crc8_step(chk, 8'(tx_byte));
`else
    assign chk_next = chk + 8'(tx_byte);
`endif

    assign busy = (state != ST_IDLE) && (state != ST_DONE);

    always_comb begin
        state_nx  = state;
        issue_req = 1'b0;
        tx_byte   = '0;
        s_ready   = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) state_nx = ST_HDR0;
            end
            ST_HDR0: begin
                issue_req = 1'b1;
                tx_byte   = N_data'(SYNC0);
                if (issue) state_nx = ST_HDR1;
            end
            ST_HDR1: begin
                issue_req = 1'b1;
                tx_byte   = N_data'(SYNC1);
                if (issue) state_nx = ST_SEQ;
            end
            ST_SEQ: begin
                issue_req = 1'b1;
                tx_byte   = N_data'(frame_seq);
                if (issue) state_nx = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                // Once s_last is taken, remaining slots become pads and upstream is closed.
                s_ready   = issue_ok & ~last_seen;
                issue_req = last_seen | s_valid;
                tx_byte   = last_seen ? PAD_BYTE : s_data;
                if (issue && (pay_cnt == LAST_SLOT)) state_nx = ST_CHK;
            end
            ST_CHK: begin
                issue_req = 1'b1;
                tx_byte   = N_data'(chk);
                if (issue) state_nx = last_seen ? ST_DONE : ST_HDR0;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            uart_wdata <= '0;
            frame_seq  <= '0;
            done       <= 1'b0;
            chk        <= '0;
            pay_cnt    <= '0;
            last_seen  <= 1'b0;
        end else begin
            state <= state_nx;
            if (issue) uart_wdata <= tx_byte;

            if (((state == ST_IDLE) || (state == ST_DONE)) && start) begin
                frame_seq <= '0;
                done      <= 1'b0;
                last_seen <= 1'b0;
            end

            if (state == ST_HDR0) begin
                chk     <= '0;
                pay_cnt <= '0;
            end

            if ((state == ST_PAYLOAD) && issue) begin
                pay_cnt <= pay_cnt + 8'd1;
                chk     <= chk_next;
                if (!last_seen && s_last) last_seen <= 1'b1;
            end

            if ((state == ST_CHK) && issue) begin
                frame_seq <= frame_seq + 8'd1;
                if (last_seen) done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Scoreboard bench for uart_frame_packer with FRAME_LEN=4: expected UART bytes are queued at stimulus time
// and popped by an independent monitor on every uart_wreq. Honours FRAME_CRC_EN for the CHK reference.
module tb_uart_frame_packer;

    logic       clk_50M = 1'b0;
    logic       rst, start, s_valid, s_last, s_ready, uart_rdy, uart_wreq, busy, done;
    logic [7:0] s_data, uart_wdata, frame_seq;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       bubble;
    } stim_t;

    stim_t      stim_q[$];
    logic [7:0] exp_q[$];
    int         total = 0;
    int         bad = 0;
    int         n_wreq = 0;
    int         rdy_gap = 10;
    logic       prev_wreq = 1'b0;
    logic       pad_phase = 1'b0;
    logic       abort = 1'b0;
    logic       drv_active = 1'b0;

    uart_frame_packer #(.N_data(8), .FRAME_LEN(4), .PAD_BYTE(8'h00)) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .uart_rdy   (uart_rdy),
        .uart_wreq  (uart_wreq),
        .uart_wdata (uart_wdata),
        .frame_seq  (frame_seq),
        .busy       (busy),
        .done       (done)
    );

    always #10 clk_50M = ~clk_50M;

    initial begin
        #800000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // uart_tx model: goes not-ready in the cycle of the strobe and stays low for rdy_gap cycles.
    initial begin
        uart_rdy = 1'b1;
        forever begin
            @(posedge clk_50M);
            #1;
            if (uart_wreq) begin
                uart_rdy = 1'b0;
                repeat (rdy_gap) @(posedge clk_50M);
                #1 uart_rdy = 1'b1;
            end
        end
    end

    always @(posedge clk_50M) begin
        #1;
        if (!rst) begin
            if (uart_wreq) begin
                n_wreq++;
                total++;
                if (prev_wreq) begin
                    bad++;
                    $display("FAIL wreq_back_to_back got=1 exp=0");
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_wreq got=%02h exp=none", uart_wdata);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (uart_wdata !== e) begin
                        bad++;
                        $display("FAIL wdata got=%02h exp=%02h", uart_wdata, e);
                    end
                end
            end
            if (pad_phase) begin
                total++;
                if (s_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL s_ready_after_last got=%b exp=0", s_ready);
                end
            end
        end
        prev_wreq = uart_wreq;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_crc8(input logic [7:0] p0, p1, p2, p3);
        logic [7:0] crc;
        logic [7:0] b[4];
        logic       fb;
        crc = 8'h00;
        b[0] = p0; b[1] = p1; b[2] = p2; b[3] = p3;
        for (int i = 0; i < 4; i++) begin
            for (int k = 7; k >= 0; k--) begin
                fb  = crc[7] ^ b[i][k];
                crc = {crc[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
        return crc;
    endfunction

    task automatic push_frame(input logic [7:0] seq, input logic [7:0] p0, p1, p2, p3,
                              input logic [7:0] sum_chk);
        logic [7:0] c;
`ifdef FRAME_CRC_EN
        c = ref_crc8(p0, p1, p2, p3);
`else
        c = sum_chk;
`endif
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(seq);
        exp_q.push_back(p0);
        exp_q.push_back(p1);
        exp_q.push_back(p2);
        exp_q.push_back(p3);
        exp_q.push_back(c);
    endtask

    task automatic push_stim(input logic [7:0] d, input logic last, input logic bubble);
        stim_t s;
        s.data = d; s.last = last; s.bubble = bubble;
        stim_q.push_back(s);
    endtask

    task automatic start_pulse();
        @(posedge clk_50M);
        #1 start = 1'b1;
        @(posedge clk_50M);
        #1 start = 1'b0;
    endtask

    // poke raises start mid-dump on a few bytes; it must be ignored while busy.
    task automatic drive_stream(input logic poke);
        int unsigned idx;
        int unsigned budget;
        logic        acc, accepted;
        idx = 0;
        drv_active = 1'b1;
        while (stim_q.size() > 0 && !abort) begin
            if (stim_q[0].bubble) begin
                s_valid = 1'b0;
                s_last  = 1'b1;
                repeat (3) @(posedge clk_50M);
                #1 s_last = 1'b0;
            end
            s_valid = 1'b1;
            s_data  = stim_q[0].data;
            s_last  = stim_q[0].last;
            if (poke && (idx % 100 == 50)) start = 1'b1;
            accepted = 1'b0;
            budget   = 0;
            while (!accepted && !abort) begin
                @(negedge clk_50M);
                acc = s_ready;
                @(posedge clk_50M);
                #1 start = 1'b0;
                if (acc) accepted = 1'b1;
                budget++;
                if (budget > 300) begin
                    total++;
                    bad++;
                    $display("FAIL accept_timeout got=%0d exp<=300", budget);
                    abort = 1'b1;
                end
            end
            if (accepted) begin
                if (stim_q[0].last) pad_phase = 1'b1;
                void'(stim_q.pop_front());
                idx++;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        drv_active = 1'b0;
    endtask

    task automatic wait_done(input string name, input int unsigned limit);
        int unsigned n;
        n = 0;
        while (!(done === 1'b1 && exp_q.size() == 0) && n < limit) begin
            @(negedge clk_50M);
            n++;
        end
        total++;
        if (n >= limit) begin
            bad++;
            $display("FAIL %s_timeout got=pending%0d exp=0", name, exp_q.size());
        end
        pad_phase = 1'b0;
        repeat (2) @(negedge clk_50M);
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] p[4];
        logic [7:0] sum;
        int unsigned n;

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0;
        repeat (3) @(posedge clk_50M);
        #1;
        check("rst_wreq",  32'(uart_wreq),  32'd0);
        check("rst_wdata", 32'(uart_wdata), 32'd0);
        check("rst_seq",   32'(frame_seq),  32'd0);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(done),       32'd0);
        check("rst_ready", 32'(s_ready),    32'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk_50M);

        // Two full frames, a stray s_last with s_valid=0 before byte 03.
        rdy_gap = 10;
        for (int i = 1; i <= 8; i++) push_stim(8'(i), i == 8, i == 3);
        push_frame(8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A);
        push_frame(8'h01, 8'h05, 8'h06, 8'h07, 8'h08, 8'h1A);
        start_pulse();
        drive_stream(1'b0);
        wait_done("t1", 2000);
        check("t1_seq", 32'(frame_seq), 32'd2);

        // Short frame padded with 00.
        push_stim(8'h10, 1'b0, 1'b0);
        push_stim(8'h20, 1'b1, 1'b0);
        push_frame(8'h00, 8'h10, 8'h20, 8'h00, 8'h00, 8'h30);
        start_pulse();
        check("t2_busy", 32'(busy), 32'd1);
        check("t2_done_cleared", 32'(done), 32'd0);
        drive_stream(1'b0);
        wait_done("t2", 2000);
        check("t2_seq", 32'(frame_seq), 32'd1);

        // Fastest legal uart_tx: ready drops for a single cycle per character.
        rdy_gap = 1;
        repeat (12) @(posedge clk_50M);
        n_wreq = 0;
        for (int i = 1; i <= 4; i++) push_stim(8'(8'h60 + i), i == 4, 1'b0);
        push_frame(8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h8A);
        start_pulse();
        drive_stream(1'b0);
        wait_done("t3", 500);
        check("t3_wreq_count", 32'(n_wreq), 32'd8);

        // Reset in the middle of the payload.
        rdy_gap = 10;
        repeat (3) @(posedge clk_50M);
        n_wreq = 0;
        for (int i = 1; i <= 8; i++) push_stim(8'(8'h40 + i), 1'b0, 1'b0);
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        start_pulse();
        fork
            drive_stream(1'b0);
        join_none
        n = 0;
        while (n_wreq < 5 && n < 2000) begin
            @(negedge clk_50M);
            n++;
        end
        check("t4_reached_payload2", 32'(n_wreq), 32'd5);
        rst   = 1'b1;
        abort = 1'b1;
        @(posedge clk_50M);
        #2;
        check("t4_wreq", 32'(uart_wreq), 32'd0);
        check("t4_busy", 32'(busy),      32'd0);
        check("t4_seq",  32'(frame_seq), 32'd0);
        check("t4_done", 32'(done),      32'd0);
        n = 0;
        while (drv_active && n < 50) begin
            @(posedge clk_50M);
            n++;
        end
        stim_q.delete();
        abort = 1'b0;
        check("t4_no_extra_bytes", 32'(exp_q.size()), 32'd0);
        @(negedge clk_50M);
        rst = 1'b0;
        repeat (15) @(posedge clk_50M);
        for (int i = 1; i <= 4; i++) push_stim(8'(8'h50 + i), i == 4, 1'b0);
        push_frame(8'h00, 8'h51, 8'h52, 8'h53, 8'h54, 8'h4A);
        start_pulse();
        drive_stream(1'b0);
        wait_done("t4b", 2000);

        // 257 frames: SEQ runs 00..FF and wraps; start pokes while busy are ignored.
        rdy_gap = 1;
        repeat (3) @(posedge clk_50M);
        for (int f = 0; f < 257; f++) begin
            sum = 8'h00;
            for (int k = 0; k < 4; k++) begin
                p[k] = 8'(f * 4 + k);
                sum  = sum + p[k];
                push_stim(p[k], (f == 256) && (k == 3), 1'b0);
            end
            push_frame(8'(f), p[0], p[1], p[2], p[3], sum);
        end
        start_pulse();
        drive_stream(1'b1);
        wait_done("t5", 20000);
        check("t5_seq_wrapped", 32'(frame_seq), 32'd1);

        // 0x31+0x32+0x33+0x34 = 0xCA; the CRC build uses ref_crc8 instead.
        rdy_gap = 3;
        repeat (5) @(posedge clk_50M);
        for (int i = 1; i <= 4; i++) push_stim(8'(8'h30 + i), i == 4, 1'b0);
        push_frame(8'h00, 8'h31, 8'h32, 8'h33, 8'h34, 8'hCA);
        start_pulse();
        drive_stream(1'b0);
        wait_done("t6", 2000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
